mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the core's instruction-fetch port and its data (load/store) port.
- Sits between the core's `prog_mem_*` / `data_mem_*` interfaces and an external memory with a req/ack handshake.
- Data accesses have priority. A streak limiter guarantees fetch forward progress.
- A timeout aborts hung transactions and reports an error.

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data has priority, a streak limiter protects fetch, and a timeout aborts hung accesses.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic       TMO_ON     = (TIMEOUT > 0);

    state_t            state, state_n;
    logic [3:0]        streak, streak_n;
    logic [7:0]        tmo, tmo_n;
    logic              mem_req_n, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;
    logic              if_ready_n, if_err_n, d_ready_n, d_err_n;
    logic              d_elig, if_elig, grant_d, grant_if, timed_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            streak    <= '0;
            tmo       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            if_ready  <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= '0;
            d_ready   <= 1'b0;
            d_err     <= 1'b0;
        end else begin
            state     <= state_n;
            streak    <= streak_n;
            tmo       <= tmo_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            if_rdata  <= if_rdata_n;
            if_ready  <= if_ready_n;
            if_err    <= if_err_n;
            d_rdata   <= d_rdata_n;
            d_ready   <= d_ready_n;
            d_err     <= d_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        streak_n    = streak;
        tmo_n       = tmo;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        d_rdata_n   = d_rdata;
        if_ready_n  = 1'b0;
        if_err_n    = 1'b0;
        d_ready_n   = 1'b0;
        d_err_n     = 1'b0;

        // A port whose ready pulse is high this cycle gets one cycle to drop or replace its request.
        d_elig    = d_req && !d_ready;
        if_elig   = if_req && !if_ready;
        grant_d   = d_elig && !(if_elig && (streak == STREAK_MAX));
        grant_if  = if_elig && !grant_d;
        timed_out = TMO_ON && !mem_ack && (tmo == TMO_LAST);

        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_n     = BUSY_D;
                    mem_req_n   = 1'b1;
                    mem_we_n    = d_we;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                    tmo_n       = '0;
                end else if (grant_if) begin
                    state_n    = BUSY_IF;
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = if_addr;
                    tmo_n      = '0;
                end
                if (!if_req || grant_if) begin
                    streak_n = '0;
                end else if (grant_d && (streak != STREAK_MAX)) begin
                    streak_n = streak + 4'd1;
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack || timed_out) begin
                    state_n   = IDLE;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    if (state == BUSY_D) begin
                        d_ready_n = 1'b1;
                        d_err_n   = !mem_ack;
                        d_rdata_n = mem_ack ? mem_rdata : '0;
                    end else begin
                        if_ready_n = 1'b1;
                        if_err_n   = !mem_ack;
                        if_rdata_n = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    tmo_n = tmo + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model is checked every cycle,
// plus literal expectations for fetch latency, grant order, store stability, timeout and reset.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 2;
    localparam int TMO  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_ready, if_err, d_ready, d_err, mem_req, mem_we;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction record plus an age and a data streak count.
    bit          started = 0;
    bit          m_busy = 0, m_is_d = 0;
    int          m_age = 0, m_streak = 0;
    logic        c_reset, c_if_req, c_d_req, c_d_we, c_ack;
    logic [31:0] c_if_addr, c_d_addr, c_d_wdata, c_rdata;
    logic        e_if_ready = 0, e_if_err = 0, e_d_ready = 0, e_d_err = 0, e_mem_req = 0, e_mem_we = 0;
    logic [31:0] e_if_rdata = 0, e_d_rdata = 0, e_mem_addr = 0, e_mem_wdata = 0;

    always @(posedge clk) begin
        bit want_d, want_if, done, err;
        c_reset = reset; c_if_req = if_req; c_d_req = d_req; c_d_we = d_we; c_ack = mem_ack;
        c_if_addr = if_addr; c_d_addr = d_addr; c_d_wdata = d_wdata; c_rdata = mem_rdata;
        #1;
        if (c_reset) begin
            started = 1; m_busy = 0; m_is_d = 0; m_age = 0; m_streak = 0;
            e_if_ready = 0; e_if_err = 0; e_d_ready = 0; e_d_err = 0; e_mem_req = 0; e_mem_we = 0;
            e_if_rdata = 0; e_d_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
        end else begin
            want_d  = c_d_req && !e_d_ready;
            want_if = c_if_req && !e_if_ready;
            e_if_ready = 0; e_if_err = 0; e_d_ready = 0; e_d_err = 0;
            if (m_busy) begin
                done = c_ack || (TMO > 0 && m_age + 1 == TMO);
                err  = !c_ack;
                if (done) begin
                    if (m_is_d) begin
                        e_d_ready = 1; e_d_err = err; e_d_rdata = err ? 32'h0 : c_rdata;
                    end else begin
                        e_if_ready = 1; e_if_err = err; e_if_rdata = err ? 32'h0 : c_rdata;
                    end
                    m_busy = 0; e_mem_req = 0; e_mem_we = 0;
                end else begin
                    m_age++;
                end
            end else begin
                if (want_d && !(want_if && m_streak == MAXS)) begin
                    m_busy = 1; m_is_d = 1; m_age = 0;
                    e_mem_req = 1; e_mem_we = c_d_we; e_mem_addr = c_d_addr; e_mem_wdata = c_d_wdata;
                    if (c_if_req && m_streak < MAXS) m_streak++;
                end else if (want_if) begin
                    m_busy = 1; m_is_d = 0; m_age = 0;
                    e_mem_req = 1; e_mem_we = 0; e_mem_addr = c_if_addr;
                    m_streak = 0;
                end
                if (!c_if_req) m_streak = 0;
            end
        end
        if (started) begin
            chk("if_ready", if_ready, e_if_ready);
            chk("if_err", if_err, e_if_err);
            chk("if_rdata", if_rdata, e_if_rdata);
            chk("d_ready", d_ready, e_d_ready);
            chk("d_err", d_err, e_d_err);
            chk("d_rdata", d_rdata, e_d_rdata);
            chk("mem_req", mem_req, e_mem_req);
            chk("mem_we", mem_we, e_mem_we);
            if (e_mem_req || c_reset) begin
                chk("mem_addr", mem_addr, e_mem_addr);
                chk("mem_wdata", mem_wdata, e_mem_wdata);
            end
        end
    end

    // Memory responder and grant observer, stepped by the stimulus process.
    int          ack_lat = -1;
    int          rcnt = 0;
    bit          prev_req = 0;
    bit          stray_ack = 0;
    logic [31:0] gaddr[$];

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
        if (mem_req && !prev_req) gaddr.push_back(mem_addr);
        if (mem_req) rcnt = prev_req ? rcnt + 1 : 0;
        prev_req  = mem_req;
        mem_ack   = (mem_req && ack_lat >= 0 && rcnt == ack_lat) || stray_ack;
        mem_rdata = mem_ack ? rd_val(mem_addr) : $urandom;
    endtask

    task automatic wait_ready(input bit is_d, input int budget, input string name);
        int  k = 0;
        logic got = 0;
        while (!got && k < budget) begin
            step();
            k++;
            got = is_d ? d_ready : if_ready;
        end
        chk(name, got, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic exp_kind[6];
        exp_kind = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) step();
        reset = 1'b0;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_ready", if_ready, 0);
        step();

        // Fetch only, ack one cycle after mem_req rises.
        ack_lat = 1; if_req = 1; if_addr = 32'h100;
        step();
        chk("fetch_mem_req", mem_req, 1);
        chk("fetch_mem_addr", mem_addr, 32'h100);
        chk("fetch_mem_we", mem_we, 0);
        step();
        chk("fetch_early_ready", if_ready, 0);
        step();
        chk("fetch_ready_t3", if_ready, 1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        chk("fetch_err", if_err, 0);
        if_req = 0;
        step();

        // Simultaneous requests, zero ack latency: data first, then fetch.
        ack_lat = 0; gaddr.delete();
        if_req = 1; if_addr = 32'h300; d_req = 1; d_we = 0; d_addr = 32'h2000;
        wait_ready(1, 10, "sim_d_ready");
        d_req = 0;
        chk("sim_d_rdata", d_rdata, 32'h2000 ^ 32'h5A5A_0000);
        wait_ready(0, 10, "sim_if_ready");
        if_req = 0;
        chk("sim_grants", gaddr.size(), 2);
        if (gaddr.size() >= 2) begin
            chk("sim_first_addr", gaddr[0], 32'h2000);
            chk("sim_second_addr", gaddr[1], 32'h300);
        end
        step();

        // Store: bus stays stable even when d_wdata changes mid-transaction.
        ack_lat = 3; cnt = 0;
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'h12345678;
        for (int k = 0; k < 12 && !d_ready; k++) begin
            step();
            if (k == 1) d_wdata = 32'hFFFF0000;
            if (mem_req) begin
                cnt++;
                chk("store_we", mem_we, 1);
                chk("store_wdata", mem_wdata, 32'h12345678);
            end
        end
        chk("store_ready", d_ready, 1);
        chk("store_busy_cycles", cnt, 4);
        d_req = 0; d_we = 0;
        step();

        // Both requesters keep re-issuing; fetch must be served between data grants.
        ack_lat = 0; gaddr.delete();
        if_req = 1; if_addr = 32'h1000; d_req = 1; d_addr = 32'h5000;
        for (int k = 0; k < 60 && (if_req || d_req || mem_req); k++) begin
            step();
            if (if_ready) begin
                if (gaddr.size() >= 6) if_req = 0; else if_addr += 4;
            end
            if (d_ready) begin
                if (gaddr.size() >= 6) d_req = 0; else d_addr += 4;
            end
        end
        chk("starve_drained", {30'd0, if_req, d_req}, 0);
        for (int i = 0; i < 6 && i < gaddr.size(); i++)
            chk($sformatf("starve_kind%0d", i), gaddr[i] >= 32'h5000, exp_kind[i]);
        step();

        // Timeout with no ack at all.
        ack_lat = -1; cnt = 0;
        d_req = 1; d_addr = 32'h77;
        for (int k = 0; k < 12 && !d_ready; k++) begin
            step();
            if (mem_req) cnt++;
        end
        chk("tmo_ready", d_ready, 1);
        chk("tmo_req_cycles", cnt, 4);
        chk("tmo_err", d_err, 1);
        chk("tmo_rdata", d_rdata, 0);
        d_req = 0;
        step();

        // Ack on the threshold cycle wins over the timeout.
        ack_lat = 3; d_req = 1; d_addr = 32'h78;
        wait_ready(1, 10, "thr_ready");
        chk("thr_err", d_err, 0);
        chk("thr_rdata", d_rdata, 32'h78 ^ 32'h5A5A_0000);
        d_req = 0;
        step();

        // Fetch timeout.
        ack_lat = -1; if_req = 1; if_addr = 32'h500;
        wait_ready(0, 10, "if_tmo_ready");
        chk("if_tmo_err", if_err, 1);
        chk("if_tmo_rdata", if_rdata, 0);
        if_req = 0;
        step();

        // Reset in the middle of a data access.
        ack_lat = -1; d_req = 1; d_addr = 32'h99;
        step(); step();
        chk("pre_rst_busy", mem_req, 1);
        reset = 1;
        step();
        chk("mid_rst_mem_req", mem_req, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_d_ready", d_ready, 0);
        chk("mid_rst_d_rdata", d_rdata, 0);
        reset = 0; d_req = 0;
        step();
        stray_ack = 1;
        step();
        stray_ack = 0;
        step();
        chk("post_rst_no_ready", d_ready, 0);
        chk("stray_ack_idle", mem_req, 0);

        ack_lat = 1; if_req = 1; if_addr = 32'h100;
        wait_ready(0, 10, "post_rst_if_ready");
        chk("post_rst_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("post_rst_if_err", if_err, 0);
        if_req = 0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
